// File: rtl/temporal_bundler.sv
// Per-dimension majority bundler: accumulates NUM_SAMPLES hypervectors, then
// presents the thresholded result until the downstream stage consumes it.
module temporal_bundler #(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_SAMPLES = 256,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DIMENSIONS-1:0] hv_in,
  input  logic                  hv_in_valid,
  output logic                  hv_in_ready,
  output logic [DIMENSIONS-1:0] hv_out,
  output logic                  hv_out_valid,
  input  logic                  hv_out_ready,
  output logic [CNT_W-1:0]      sample_count
);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q [DIMENSIONS];
  logic [CNT_W-1:0]        cnt_d [DIMENSIONS];
  logic [CNT_W-1:0]        sample_count_q, sample_count_d;
  logic [DIMENSIONS-1:0]   hv_out_q, hv_out_d;
  logic                    hv_out_valid_q, hv_out_valid_d;
  logic                    last_sample;

  assign last_sample = (sample_count_q == CNT_W'(NUM_SAMPLES - 1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sample_count_d = sample_count_q;
    hv_out_d       = hv_out_q;
    hv_out_valid_d = hv_out_valid_q;

    if (clear) begin
      cnt_d          = '{default: '0};
      sample_count_d = '0;
      hv_out_valid_d = 1'b0;
      state_d        = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (hv_in_valid) begin
            // Threshold uses the updated count so the final sample is included.
            for (int unsigned i = 0; i < DIMENSIONS; i++) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(hv_in[i]);
              if (last_sample)
                hv_out_d[i] = (cnt_d[i] > CNT_W'(NUM_SAMPLES / 2));
            end
            sample_count_d = sample_count_q + CNT_W'(1);
            if (last_sample) begin
              hv_out_valid_d = 1'b1;
              state_d        = ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (hv_out_ready) begin
            cnt_d          = '{default: '0};
            sample_count_d = '0;
            hv_out_valid_d = 1'b0;
            state_d        = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      cnt_q          <= '{default: '0};
      sample_count_q <= '0;
      hv_out_q       <= '0;
      hv_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sample_count_q <= sample_count_d;
      hv_out_q       <= hv_out_d;
      hv_out_valid_q <= hv_out_valid_d;
    end
  end

  assign hv_in_ready  = (state_q == ST_ACCUM) && !rst;
  assign hv_out       = hv_out_q;
  assign hv_out_valid = hv_out_valid_q;
  assign sample_count = sample_count_q;

endmodule
